// File: rtl/sfp_accum.sv
// Multi-pass accumulating output stage: per-address signed lane accumulation with saturation,
// optional ReLU on the final pass, and a one-entry valid/ready output register.
module sfp_accum #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16,
  parameter int addr_bw = $clog2(depth)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*psum_bw-1:0]   in_data,
  input  logic [addr_bw-1:0]       in_addr,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic                     relu_en,
  input  logic                     clr_sat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [col*psum_bw-1:0]   out_data,
  output logic [addr_bw-1:0]       out_addr,
  output logic                     sat_flag
);

  localparam int row_bw = col * psum_bw;
  localparam logic signed [psum_bw-1:0] lane_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw-1:0] lane_min = {1'b1, {(psum_bw-1){1'b0}}};

  logic [row_bw-1:0]  acc_q [depth];
  logic [row_bw-1:0]  acc_d [depth];
  logic [depth-1:0]   hit;
  logic [row_bw-1:0]  rd_row;
  logic [row_bw-1:0]  sum_row;
  logic [row_bw-1:0]  relu_row;
  logic [col-1:0]     clip;

  logic               accept;
  logic               in_range;
  logic               do_beat;
  logic               load;

  logic               out_valid_q, out_valid_d;
  logic [row_bw-1:0]  out_data_q, out_data_d;
  logic [addr_bw-1:0] out_addr_q, out_addr_d;
  logic               sat_q, sat_d;

  // The output holds a single row, so any beat waits while it is occupied and not draining.
  assign in_ready = !out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign in_range = {1'b0, in_addr} < (addr_bw+1)'(depth);
  assign do_beat  = accept & in_range;
  assign load     = do_beat & in_last;

  for (genvar gi = 0; gi < depth; gi++) begin : g_hit
    assign hit[gi] = (in_addr == addr_bw'(gi));
  end

  // Combinational bank read so a beat always sees the previous cycle's write.
  always_comb begin
    rd_row = '0;
    for (int e = 0; e < depth; e++) begin
      if (hit[e]) rd_row = acc_q[e];
    end
  end

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    logic signed [psum_bw-1:0] in_l;
    logic signed [psum_bw-1:0] acc_l;
    logic signed [psum_bw-1:0] sum_l;
    logic signed [psum_bw:0]   wide;

    assign in_l  = in_data[gi*psum_bw +: psum_bw];
    assign acc_l = in_first ? '0 : rd_row[gi*psum_bw +: psum_bw];
    assign wide  = {in_l[psum_bw-1], in_l} + {acc_l[psum_bw-1], acc_l};
    // Top two bits disagree exactly when the extra-bit sum left the lane range.
    assign clip[gi] = wide[psum_bw] ^ wide[psum_bw-1];
    assign sum_l = !clip[gi] ? wide[psum_bw-1:0] : (wide[psum_bw] ? lane_min : lane_max);
    assign sum_row[gi*psum_bw +: psum_bw]  = sum_l;
    assign relu_row[gi*psum_bw +: psum_bw] = (relu_en && sum_l[psum_bw-1]) ? '0 : sum_l;
  end

  always_comb begin
    for (int e = 0; e < depth; e++) begin
      acc_d[e] = (do_beat && hit[e]) ? sum_row : acc_q[e];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = relu_row;
      out_addr_d  = in_addr;
    end
    sat_d = sat_q;
    if (clr_sat) sat_d = 1'b0;
    if (do_beat && |clip) sat_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < depth; e++) acc_q[e] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      for (int e = 0; e < depth; e++) acc_q[e] <= acc_d[e];
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign sat_flag  = sat_q;

endmodule
